id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 27 ++
 rtl/id_ex_stage_forward_mux.sv | 25 ++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU opcode encodings, the hard-wired zero register,
// and the forwarding match rule used by the ID/EX operand muxes.
package mips_pkg;

  // 4-bit ALU operation encodings carried from decode into execute
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_NOR = 4'h5;
  localparam logic [3:0] ALU_SLT = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SRL = 4'h8;
  localparam logic [3:0] ALU_SRA = 4'h9;
  localparam logic [3:0] ALU_LUI = 4'hA;

  // $zero is hard-wired; writes to it are discarded, so it is never forwarded
  localparam logic [4:0] REG_ZERO = 5'd0;

  // A later stage supplies the operand when it writes the register being read
  function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] addr);
    return we && (rd == addr) && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Operand bypass for one register read: EX/MEM beats MEM/WB, which beats the
// register-file value.
module forward_mux #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] raw_data,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] fwd_data
);
  import mips_pkg::*;

  // Later assignment wins, so the younger EX/MEM result takes priority
  always_comb begin
    fwd_data = raw_data;
    if (fwd_hit(memwb_reg_write, memwb_rd, addr)) fwd_data = memwb_result;
    if (fwd_hit(exmem_reg_write, exmem_rd, addr)) fwd_data = exmem_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate extension,
// load-use bubble insertion and a saturating bubble counter.
// Handshake: decode presents an instruction with id_valid; it is consumed on a
// rising edge only when id_stall is low. id_stall high means decode must hold
// its instruction unchanged; flush discards the EX slot and never stalls.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm16,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [3:0]        alu_op,
  input  logic              use_imm,
  input  logic              imm_signed,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              reg_write,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_input_a,
  output logic [DATA_W-1:0] ex_input_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [3:0]        ex_alu_op,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              ex_is_store,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_count
);
  import mips_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [DATA_W-1:0] imm_ext;
  logic              hazard;
  logic              capture;

  forward_mux #(.DATA_W(DATA_W)) u_fwd_rs (
    .addr            (rs_addr),
    .raw_data        (rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rs_fwd)
  );

  forward_mux #(.DATA_W(DATA_W)) u_fwd_rt (
    .addr            (rt_addr),
    .raw_data        (rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (rt_fwd)
  );

  // Upper bits copy imm16[15] only for signed immediates
  assign imm_ext = {{(DATA_W-16){imm16[15] & imm_signed}}, imm16};

  // A load in EX cannot forward in time; rt matters only when it is read
  // (register-form ALU op, or the data of a store)
  assign hazard = ex_valid & ex_is_load & ex_reg_write & (ex_rd != REG_ZERO) &
                  id_valid & ((ex_rd == rs_addr) |
                              ((ex_rd == rt_addr) & (~use_imm | is_store)));

  assign id_stall = (stall_in | hazard) & ~flush;
  assign capture  = ~flush & ~stall_in & ~hazard;

  // EX slot update: flush > stall_in > hazard bubble > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
      ex_rd         <= REG_ZERO;
      ex_alu_op     <= ALU_ADD;
      ex_input_a    <= '0;
      ex_input_b    <= '0;
      ex_store_data <= '0;
    end else if (flush || (!stall_in && hazard)) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
      ex_rd         <= REG_ZERO;
      ex_alu_op     <= ALU_ADD;
    end else if (capture) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid & reg_write;
      ex_is_load    <= id_valid & is_load;
      ex_is_store   <= id_valid & is_store;
      ex_rd         <= rd_addr;
      ex_alu_op     <= alu_op;
      ex_input_a    <= rs_fwd;
      ex_input_b    <= use_imm ? imm_ext : rt_fwd;
      ex_store_data <= rt_fwd;
    end
  end

  // Count inserted load-use bubbles, sticking at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (!flush && !stall_in && hazard && (bubble_count != CNT_MAX)) begin
      bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table-driven capture/forwarding vectors through an
// expected-value queue, then hand-written load-use, flush, stall, saturation
// and asynchronous-reset sequences.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int EXP_W = 4 + 5 + 4 + 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [DW-1:0] rs_data, rt_data;
  logic [15:0]   imm16;
  logic [4:0]    rs_addr, rt_addr, rd_addr;
  logic [3:0]    alu_op;
  logic          use_imm, imm_signed, is_load, is_store, reg_write;
  logic          stall_in, flush;
  logic          exmem_reg_write, memwb_reg_write;
  logic [4:0]    exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_result, memwb_result;

  logic          ex_valid, ex_reg_write, ex_is_load, ex_is_store, id_stall;
  logic [DW-1:0] ex_input_a, ex_input_b, ex_store_data;
  logic [3:0]    ex_alu_op;
  logic [4:0]    ex_rd;
  logic [15:0]   bubble_count;

  // Narrow-counter copy sharing all inputs, used to reach saturation quickly
  logic          s_ex_valid, s_ex_reg_write, s_ex_is_load, s_ex_is_store, s_id_stall;
  logic [DW-1:0] s_ex_input_a, s_ex_input_b, s_ex_store_data;
  logic [3:0]    s_ex_alu_op;
  logic [4:0]    s_ex_rd;
  logic [1:0]    s_bubble_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic          idv;
    logic [4:0]    rs_a, rt_a, rd_a;
    logic [DW-1:0] rs_d, rt_d;
    logic [15:0]   imm;
    logic [3:0]    alu;
    logic          ui, is, ld, st, rw;
    logic          xw;
    logic [4:0]    xrd;
    logic [DW-1:0] xres;
    logic          mw;
    logic [4:0]    mrd;
    logic [DW-1:0] mres;
    logic [DW-1:0] ea, eb, esd;
  } vec_t;

  vec_t vecs[10];

  id_ex_stage #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_data(rs_data),
    .rt_data(rt_data), .imm16(imm16), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .alu_op(alu_op), .use_imm(use_imm),
    .imm_signed(imm_signed), .is_load(is_load), .is_store(is_store),
    .reg_write(reg_write), .stall_in(stall_in), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ex_valid(ex_valid),
    .ex_input_a(ex_input_a), .ex_input_b(ex_input_b),
    .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .id_stall(id_stall), .bubble_count(bubble_count)
  );

  id_ex_stage #(.DATA_W(DW), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs_data(rs_data),
    .rt_data(rt_data), .imm16(imm16), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .alu_op(alu_op), .use_imm(use_imm),
    .imm_signed(imm_signed), .is_load(is_load), .is_store(is_store),
    .reg_write(reg_write), .stall_in(stall_in), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_rd(memwb_rd), .memwb_result(memwb_result), .ex_valid(s_ex_valid),
    .ex_input_a(s_ex_input_a), .ex_input_b(s_ex_input_b),
    .ex_store_data(s_ex_store_data), .ex_alu_op(s_ex_alu_op), .ex_rd(s_ex_rd),
    .ex_reg_write(s_ex_reg_write), .ex_is_load(s_ex_is_load),
    .ex_is_store(s_ex_is_store), .id_stall(s_id_stall),
    .bubble_count(s_bubble_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    n_fail++;
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] actual_out();
    return {ex_valid, ex_reg_write, ex_is_load, ex_is_store, ex_rd, ex_alu_op,
            ex_input_a, ex_input_b, ex_store_data};
  endfunction

  function automatic logic [EXP_W-1:0] expect_of(input vec_t v);
    return {v.idv, v.idv & v.rw, v.idv & v.ld, v.idv & v.st, v.rd_a, v.alu,
            v.ea, v.eb, v.esd};
  endfunction

  function automatic vec_t mk(
      input logic idv, input logic [4:0] rs_a, rt_a, rd_a,
      input logic [DW-1:0] rs_d, rt_d, input logic [15:0] imm,
      input logic [3:0] alu, input logic ui, is, ld, st, rw,
      input logic xw, input logic [4:0] xrd, input logic [DW-1:0] xres,
      input logic mw, input logic [4:0] mrd, input logic [DW-1:0] mres,
      input logic [DW-1:0] ea, eb, esd);
    vec_t v;
    v.idv = idv; v.rs_a = rs_a; v.rt_a = rt_a; v.rd_a = rd_a;
    v.rs_d = rs_d; v.rt_d = rt_d; v.imm = imm; v.alu = alu;
    v.ui = ui; v.is = is; v.ld = ld; v.st = st; v.rw = rw;
    v.xw = xw; v.xrd = xrd; v.xres = xres;
    v.mw = mw; v.mrd = mrd; v.mres = mres;
    v.ea = ea; v.eb = eb; v.esd = esd;
    return v;
  endfunction

  // Reference forwarding rule
  function automatic logic [DW-1:0] ref_fwd(input logic [4:0] a,
      input logic [DW-1:0] raw, input logic xw, input logic [4:0] xrd,
      input logic [DW-1:0] xres, input logic mw, input logic [4:0] mrd,
      input logic [DW-1:0] mres);
    if (a != 5'd0 && xw && xrd == a) return xres;
    if (a != 5'd0 && mw && mrd == a) return mres;
    return raw;
  endfunction

  task automatic drive_idle();
    id_valid = 0; rs_data = '0; rt_data = '0; imm16 = '0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_op = 0;
    use_imm = 0; imm_signed = 0; is_load = 0; is_store = 0; reg_write = 0;
    stall_in = 0; flush = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_valid = v.idv; rs_addr = v.rs_a; rt_addr = v.rt_a; rd_addr = v.rd_a;
    rs_data = v.rs_d; rt_data = v.rt_d; imm16 = v.imm; alu_op = v.alu;
    use_imm = v.ui; imm_signed = v.is; is_load = v.ld; is_store = v.st;
    reg_write = v.rw;
    exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_reg_write = v.mw; memwb_rd = v.mrd; memwb_result = v.mres;
  endtask

  // Drive on the falling edge, expect the registered result after the next rise
  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk);
    drive_vec(v);
    exp_q.push_back(expect_of(v));
    @(posedge clk);
    #1;
    check(name, actual_out(), exp_q.pop_front());
  endtask

  // Load to r7 enters EX, dependent instruction stalls one cycle, then
  // captures the loaded value from MEM/WB
  task automatic load_use(input int n);
    @(negedge clk);
    drive_idle();
    id_valid = 1; rs_addr = 1; rt_addr = 2; rd_addr = 7; is_load = 1;
    reg_write = 1; use_imm = 1; imm16 = 16'h0004;
    @(posedge clk); #1;
    check("lu_load_in_ex", {ex_valid, ex_is_load, ex_rd}, {1'b1, 1'b1, 5'd7});
    @(negedge clk);
    drive_idle();
    id_valid = 1; rs_addr = 7; rt_addr = 3; rd_addr = 8; reg_write = 1;
    rs_data = 32'h0000_0BAD;
    #1;
    check("lu_id_stall", id_stall, 1'b1);
    @(posedge clk); #1;
    check("lu_bubble_ctrl", {ex_valid, ex_reg_write, ex_is_load, ex_is_store}, 4'b0000);
    check("lu_count", bubble_count, 16'(n));
    check("lu_count_sat", s_bubble_count, (n > 3) ? 2'd3 : 2'(n));
    check("lu_stall_drop", id_stall, 1'b0);
    @(negedge clk);
    memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h0000_0077 + n;
    @(posedge clk); #1;
    check("lu_capture", {ex_valid, ex_rd, ex_input_a}, {1'b1, 5'd8, 32'h0000_0077 + n});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    rst_n = 0;
    #1;
    check("reset_outputs", {actual_out(), bubble_count, id_stall},
          {{EXP_W{1'b0}}, 16'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("post_reset_empty", {ex_valid, id_stall}, 2'b00);

    vecs[0] = mk(1, 3, 4, 2, 32'h0000_00F0, 32'h1234_5678, 16'hFFFF, 4'h0, 1, 1, 0, 0, 1,
                 0, 0, '0, 0, 0, '0, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h1234_5678);
    vecs[1] = mk(1, 3, 4, 2, 32'h0000_00F0, 32'h1234_5678, 16'hFFFF, 4'h0, 1, 0, 0, 0, 1,
                 0, 0, '0, 0, 0, '0, 32'h0000_00F0, 32'h0000_FFFF, 32'h1234_5678);
    vecs[2] = mk(1, 5, 6, 3, 32'h0000_0005, 32'h0000_AAAA, 16'h0000, 4'h1, 0, 0, 0, 0, 1,
                 1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222,
                 32'h1111_1111, 32'h0000_AAAA, 32'h0000_AAAA);
    vecs[3] = mk(1, 0, 0, 4, 32'hDEAD_0000, 32'h0000_BEEF, 16'h0000, 4'h2, 0, 0, 0, 0, 1,
                 1, 0, 32'h0000_0001, 1, 0, 32'h0000_0002,
                 32'hDEAD_0000, 32'h0000_BEEF, 32'h0000_BEEF);
    vecs[4] = mk(1, 8, 9, 5, 32'h0000_0008, 32'h0000_0009, 16'h0000, 4'h3, 0, 0, 0, 0, 1,
                 1, 9, 32'h9999_0000, 1, 8, 32'h8888_0000,
                 32'h8888_0000, 32'h9999_0000, 32'h9999_0000);
    vecs[5] = mk(1, 10, 12, 6, 32'h0000_000A, 32'h0000_1200, 16'h0000, 4'h4, 0, 0, 0, 0, 1,
                 0, 10, 32'h0BAD_0BAD, 1, 10, 32'h1010_1010,
                 32'h1010_1010, 32'h0000_1200, 32'h0000_1200);
    vecs[6] = mk(1, 1, 11, 0, 32'h0000_0100, 32'h0000_0005, 16'h0010, 4'h0, 1, 1, 0, 1, 0,
                 0, 0, '0, 1, 11, 32'hCAFE_F00D,
                 32'h0000_0100, 32'h0000_0010, 32'hCAFE_F00D);
    vecs[7] = mk(0, 3, 4, 13, 32'h0000_0003, 32'h0000_0004, 16'h0000, 4'h5, 0, 0, 1, 1, 1,
                 0, 0, '0, 0, 0, '0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004);
    vecs[8] = mk(1, 2, 5, 9, 32'h0000_2000, 32'h0000_0055, 16'h8000, 4'h0, 1, 1, 1, 0, 1,
                 0, 0, '0, 0, 0, '0, 32'h0000_2000, 32'hFFFF_8000, 32'h0000_0055);
    vecs[9] = mk(1, 1, 2, 14, 32'h0000_0001, 32'h0000_0002, 16'h0000, 4'h2, 0, 0, 0, 0, 1,
                 0, 0, '0, 0, 0, '0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002);

    for (int i = 0; i < 10; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Randomised forwarding mix with small addresses so matches are frequent
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      logic [DW-1:0] rtf;
      v = mk(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(1, 31)), $urandom, $urandom, 16'($urandom),
             4'($urandom_range(0, 10)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
             '0, '0, '0);
      v.ea = ref_fwd(v.rs_a, v.rs_d, v.xw, v.xrd, v.xres, v.mw, v.mrd, v.mres);
      rtf = ref_fwd(v.rt_a, v.rt_d, v.xw, v.xrd, v.xres, v.mw, v.mrd, v.mres);
      v.eb = v.ui ? (v.is ? {{16{v.imm[15]}}, v.imm} : {16'h0000, v.imm}) : rtf;
      v.esd = rtf;
      apply_vec($sformatf("rand%0d", i), v);
    end

    check("count_zero_before_lu", bubble_count, 16'd0);
    load_use(1);

    // Flush wins over stall_in
    @(negedge clk);
    drive_idle();
    stall_in = 1; flush = 1;
    #1;
    check("flush_id_stall", id_stall, 1'b0);
    @(posedge clk); #1;
    check("flush_clears", {ex_valid, ex_reg_write, ex_is_load, ex_is_store}, 4'b0000);

    // stall_in alone holds the EX slot
    @(negedge clk);
    drive_idle();
    id_valid = 1; rs_addr = 1; rs_data = 32'h0000_0055; rd_addr = 4; reg_write = 1;
    @(posedge clk); #1;
    check("pre_stall_capture", ex_input_a, 32'h0000_0055);
    @(negedge clk);
    stall_in = 1; rs_data = 32'h0000_0066;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_id_stall", id_stall, 1'b1);
      @(posedge clk); #1;
      check("stall_hold", {ex_valid, ex_input_a}, {1'b1, 32'h0000_0055});
      @(negedge clk);
    end
    stall_in = 0;
    @(posedge clk); #1;
    check("stall_release", ex_input_a, 32'h0000_0066);

    // Further load-use bubbles drive the 2-bit copy into saturation
    for (int n = 2; n <= 5; n++) load_use(n);

    // Asynchronous reset mid-cycle with an instruction in flight
    @(negedge clk);
    drive_idle();
    id_valid = 1; rs_addr = 1; rs_data = 32'h0000_ABCD; rd_addr = 6;
    reg_write = 1; is_store = 1; alu_op = 4'h3;
    @(posedge clk); #1;
    check("pre_reset_valid", {ex_valid, ex_input_a}, {1'b1, 32'h0000_ABCD});
    #2;
    rst_n = 0;
    #1;
    check("async_reset_outputs", {actual_out(), bubble_count, id_stall},
          {{EXP_W{1'b0}}, 16'd0, 1'b0});
    check("async_reset_small", s_bubble_count, 2'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1;
    @(posedge clk); #1;
    check("restart_empty", {ex_valid, id_stall, bubble_count}, {1'b0, 1'b0, 16'd0});

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
